my_mod: RTL and testbench

- Windowed scale-and-accumulate stage on a 9-bit unsigned datapath.
- Accepts one sample per valid/ready handshake and scales it by a left shift of X.
- Sums Y consecutive samples, then presents the sum saturated to DATA_W bits, with an overflow flag, on a valid/ready output.
- Sits between a sample producer and a consumer in the datapath; parameters are overridable per instance (e.g. X=1, Y=2, or X=3).

---
 rtl/my_mod_pkg.sv | 21 ++
 rtl/my_mod_acc.sv | 36 +++
 rtl/my_mod.sv | 55 +++++
 tb/tb_my_mod.sv | 118 +++++++++++
 4 files changed

// File: rtl/my_mod_pkg.sv
// my_mod_pkg: shared widths and unsigned saturation helper for the scale-and-accumulate stage.
package my_mod_pkg;
  localparam int DATA_W_DEF = 9;
  typedef struct packed {
    logic [31:0] val;
    logic        ovf;
  } sat_t;
  // Wide enough that Y samples of (2^DATA_W-1)<<X never wrap.
  function automatic int acc_w(input int data_w, input int x, input int y);
    return data_w + x + $clog2(y) + 1;
  endfunction
  localparam int ACC_W_DEF = acc_w(DATA_W_DEF, 1, 2);
  function automatic sat_t sat_u(input logic [63:0] total, input int data_w);
    sat_t r;
    logic [63:0] max_v;
    max_v = (64'd1 << data_w) - 64'd1;
    r.ovf = total > max_v;
    r.val = 32'(r.ovf ? max_v : total);
    return r;
  endfunction
endpackage

// File: rtl/my_mod_acc.sv
// my_mod_acc: window accumulator and sample counter; done flags the sample that completes a window.
module my_mod_acc
  import my_mod_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int X      = 1,
  parameter int Y      = 2,
  parameter int ACC_W  = acc_w(DATA_W, X, Y)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              take,
  input  logic [DATA_W-1:0] sample,
  output logic              done,
  output logic [ACC_W-1:0]  total
);
  localparam int CNT_W = (Y > 1) ? $clog2(Y) : 1;
  logic [ACC_W-1:0] acc_q, acc_d, ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    ext   = ACC_W'(sample) << X;
    total = acc_q + ext;
    done  = take && (cnt_q == CNT_W'(Y - 1));
    acc_d = done ? '0 : take ? total : acc_q;
    cnt_d = done ? '0 : take ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/my_mod.sv
// my_mod: windowed scale-and-accumulate with saturated result on a valid/ready output.
module my_mod
  import my_mod_pkg::*;
#(
  parameter int X      = 1,
  parameter int Y      = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] foo,
  input  logic              foo_valid,
  output logic              foo_ready,
  output logic [DATA_W-1:0] sum,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              overflow
);
  localparam int ACC_W = acc_w(DATA_W, X, Y);
  logic              take, done, sat_ovf;
  logic [ACC_W-1:0]  total;
  logic [DATA_W-1:0] sum_q, sum_d, sat_val;
  logic              sum_valid_q, sum_valid_d, ovf_q, ovf_d;
  my_mod_acc #(.DATA_W(DATA_W), .X(X), .Y(Y), .ACC_W(ACC_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .take  (take),
    .sample(foo),
    .done  (done),
    .total (total)
  );
  // A completing window reloads the result even while the old one drains: no bubble.
  always_comb begin
    foo_ready            = !(sum_valid_q && !sum_ready);
    take                 = foo_valid && foo_ready;
    {sat_val, sat_ovf}   = (DATA_W + 1)'(sat_u(64'(total), DATA_W));
    sum_d                = done ? sat_val : sum_q;
    ovf_d                = done ? sat_ovf : ovf_q;
    sum_valid_d          = done ? 1'b1 : (sum_valid_q && sum_ready) ? 1'b0 : sum_valid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= sum_valid_d;
    end
  end
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign sum_valid = sum_valid_q;
endmodule

// File: tb/tb_my_mod.sv
// tb_my_mod: drives a default (X=1,Y=2) and an X=0,Y=1 instance from shared inputs against a window-sum model.
module tb_my_mod;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] foo;
  logic       foo_valid, sum_ready;
  logic [1:0] rdy, sv, ov;
  logic [8:0] sm [2];
  int checks = 0, failures = 0;
  int xs [2] = '{1, 0};
  int ys [2] = '{2, 1};
  int wsum [2], wcnt [2], es [2];
  bit ev [2], eo [2];

  my_mod u_a (
    .clk(clk), .rst_n(rst_n), .foo(foo), .foo_valid(foo_valid), .foo_ready(rdy[0]),
    .sum(sm[0]), .sum_valid(sv[0]), .sum_ready(sum_ready), .overflow(ov[0])
  );
  my_mod #(.X(0), .Y(1)) u_b (
    .clk(clk), .rst_n(rst_n), .foo(foo), .foo_valid(foo_valid), .foo_ready(rdy[1]),
    .sum(sm[1]), .sum_valid(sv[1]), .sum_ready(sum_ready), .overflow(ov[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      wsum[i] = 0; wcnt[i] = 0; es[i] = 0; ev[i] = 0; eo[i] = 0;
    end
  endtask

  task automatic step(input bit v, input int d, input bit r);
    bit acc;
    @(negedge clk);
    foo_valid = v; foo = d[8:0]; sum_ready = r;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!(ev[i] && !r)));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      acc = v && !(ev[i] && !r);
      if (acc) begin
        wsum[i] += d << xs[i];
        wcnt[i]++;
      end
      if (acc && wcnt[i] == ys[i]) begin
        ev[i] = 1; eo[i] = wsum[i] > 511; es[i] = eo[i] ? 511 : wsum[i];
        wsum[i] = 0; wcnt[i] = 0;
      end else if (ev[i] && r) ev[i] = 0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), 32'(sv[i]), 32'(ev[i]));
      chk($sformatf("sum%0d", i), 32'(sm[i]), 32'(es[i]));
      chk($sformatf("ovf%0d", i), 32'(ov[i]), 32'(eo[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0; foo = '0; foo_valid = 1'b0; sum_ready = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(sv[i]), 0);
      chk("rst_sum", 32'(sm[i]), 0);
      chk("rst_ovf", 32'(ov[i]), 0);
    end
    #22 rst_n = 1'b1;
    step(1, 5, 1); step(1, 5, 1);
    chk("t1_sum", 32'(sm[0]), 20);
    chk("t1_ovf", 32'(ov[0]), 0);
    step(1, 200, 1); step(1, 100, 1);
    chk("t2_sat", 32'(sm[0]), 511);
    chk("t2_ovf", 32'(ov[0]), 1);
    step(1, 1, 1); step(1, 2, 1);
    chk("t2_next", 32'(sm[0]), 6);
    step(0, 0, 1);
    step(1, 10, 1); step(1, 10, 0);
    step(1, 77, 0); step(1, 99, 0);
    chk("bp_hold", 32'(sm[0]), 40);
    chk("bp_ready", 32'(rdy[0]), 0);
    step(0, 0, 1);
    chk("bp_drop", 32'(sv[0]), 0);
    step(1, 5, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_valid", 32'(sv[i]), 0);
      chk("mid_rst_sum", 32'(sm[i]), 0);
      chk("mid_rst_ovf", 32'(ov[i]), 0);
    end
    #4 rst_n = 1'b1;
    step(1, 3, 1); step(1, 4, 1);
    chk("rst_win", 32'(sm[0]), 14);
    for (int k = 1; k <= 6; k++) begin
      step(1, k, 1);
      if (k % 2 == 0) chk($sformatf("stream%0d", k), 32'(sm[0]), 32'(2 * (2 * k - 1)));
    end
    step(1, 9, 1);
    chk("b_9", 32'(sm[1]), 9);
    step(1, 511, 1);
    chk("b_511", 32'(sm[1]), 511);
    chk("b_511_ovf", 32'(ov[1]), 0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 511)), $urandom_range(0, 3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
